// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO transmitter and its counter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int PISO_N = 16;

  // Counter width for an n-bit word; a 1-bit counter still covers n = 2.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_16b_if.sv
// Load and serial handshake bundle; slave is the transmitter, master is its environment.
interface piso_16b_if
  import piso_pkg::*;
#(
  parameter int N = PISO_N
);

  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] load_data;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_last;

  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_out, ser_valid, ser_last
  );

  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_out, ser_valid, ser_last
  );

endinterface

// File: rtl/piso_cnt.sv
// Beat counter with synchronous clear (priority) and increment enable; zero-latency output.
module piso_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/piso_16b.sv
// Parallel-in/serial-out, MSB first; first bit valid the cycle after load, one bit per ser_fire.
// Serial outputs hold under ser_ready back-pressure; load_ready opens in the final beat for gapless streaming.
module piso_16b
  import piso_pkg::*;
#(
  parameter int N = PISO_N
) (
  input  logic          clk,
  input  logic          rst_n,
  piso_16b_if.slave     bus
);

  localparam int CW = cnt_w(N);

  state_e        state_q;
  state_e        state_d;
  logic [N-1:0]  shreg_q;
  logic [N-1:0]  shreg_d;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          cnt_inc;

  logic ser_valid;
  logic ser_last;
  logic ser_fire;
  logic load_ready;
  logic load_fire;

  assign ser_valid  = (state_q == SHIFT);
  assign ser_last   = ser_valid && (cnt == CW'(N - 1));
  assign ser_fire   = ser_valid && bus.ser_ready;
  assign load_ready = (state_q == IDLE) || (ser_fire && ser_last);
  assign load_fire  = bus.load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_fire) begin
          shreg_d = bus.load_data;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_fire) begin
          if (ser_last) begin
            // Final beat: either chain straight into the next word or fall back to idle.
            cnt_clr = 1'b1;
            if (load_fire) begin
              shreg_d = bus.load_data;
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d = {shreg_q[N-2:0], 1'b0};
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  piso_cnt #(
    .W (CW)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  assign bus.load_ready = load_ready;
  assign bus.ser_valid  = ser_valid;
  assign bus.ser_last   = ser_last;
  assign bus.ser_out    = ser_valid && shreg_q[N-1];

endmodule

// File: tb/tb_piso_16b.sv
// Bench for piso_16b: directed scenarios plus random traffic, checked each cycle against a bit-queue model.
module tb_piso_16b;
  import piso_pkg::*;

  localparam int N = PISO_N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  piso_16b_if #(.N(N)) bus ();

  piso_16b #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: the bits still owed to the receiver, front = bit currently on the wire.
  bit exp_q[$];
  // Bits (and their last flags) actually accepted from the DUT.
  bit rx_q[$];
  bit rxl_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    bit m_valid, m_out, m_last, m_ready, lf, sf;
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_load_ready", bus.load_ready, 1);
      chk("rst_ser_valid", bus.ser_valid, 0);
      chk("rst_ser_out", bus.ser_out, 0);
      chk("rst_ser_last", bus.ser_last, 0);
    end else begin
      m_valid = (exp_q.size() > 0);
      m_out   = m_valid ? exp_q[0] : 1'b0;
      m_last  = (exp_q.size() == 1);
      m_ready = !m_valid || (bus.ser_ready && m_last);
      chk("ser_valid", bus.ser_valid, m_valid);
      chk("ser_out", bus.ser_out, m_out);
      chk("ser_last", bus.ser_last, m_last);
      chk("load_ready", bus.load_ready, m_ready);
      if (bus.ser_valid && bus.ser_ready) begin
        rx_q.push_back(bus.ser_out);
        rxl_q.push_back(bus.ser_last);
      end
      lf = bus.load_valid && m_ready;
      sf = m_valid && bus.ser_ready;
      if (sf) void'(exp_q.pop_front());
      if (lf) for (int i = N - 1; i >= 0; i--) exp_q.push_back(bus.load_data[i]);
    end
  end

  function automatic logic [31:0] rx_bits(input int first, input int count);
    logic [31:0] w = '0;
    for (int i = first; i < first + count; i++) w = {w[30:0], rx_q[i]};
    return w;
  endfunction

  function automatic int last_count();
    int c = 0;
    foreach (rxl_q[i]) c += int'(rxl_q[i]);
    return c;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic load_word(input logic [N-1:0] w);
    int n = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.load_ready && n < 100);
    if (!bus.load_ready) chk("load_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
  endtask

  // Counts cycles with ser_valid high until the word drains; optional ready toggling starting low.
  task automatic drain(input bit toggle, output int ncyc);
    ncyc = 0;
    bus.ser_ready = toggle ? 1'b0 : 1'b1;
    while (1) begin
      @(negedge clk);
      if (!bus.ser_valid) break;
      ncyc++;
      if (ncyc > 200) begin
        chk("drain_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
      if (toggle) bus.ser_ready = ~bus.ser_ready;
    end
    bus.ser_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit fired;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.ser_ready  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_load_ready", bus.load_ready, 1);
    chk("post_rst_ser_valid", bus.ser_valid, 0);
    chk("post_rst_ser_out", bus.ser_out, 0);
    chk("post_rst_ser_last", bus.ser_last, 0);

    // Single word, receiver always ready.
    rx_q.delete(); rxl_q.delete();
    bus.ser_ready = 1'b1;
    load_word(16'hA5C3);
    chk("single_first_bit", bus.ser_out, 1);
    drain(1'b0, n);
    chk("single_cycles", n, 16);
    chk("single_word", rx_bits(0, 16), 32'h0000_A5C3);
    chk("single_last_pos", (rxl_q.size() == 16) && rxl_q[15] && (last_count() == 1), 1);

    // Back-pressure: ready toggles every cycle.
    rx_q.delete(); rxl_q.delete();
    load_word(16'h8001);
    drain(1'b1, n);
    chk("bp_cycles", n, 32);
    chk("bp_word", rx_bits(0, 16), 32'h0000_8001);
    chk("bp_bits", rx_q.size(), 16);

    // Back-to-back words with load_valid held high.
    rx_q.delete(); rxl_q.delete();
    bus.ser_ready  = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hFFFF;
    @(negedge clk);
    @(posedge clk);
    #1 bus.load_data = 16'h0000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.load_ready && n < 100);
    chk("b2b_ready_beat", n, 16);
    chk("b2b_ready_in_last", bus.ser_last, 1);
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
    drain(1'b0, n);
    chk("b2b_second_cycles", n, 16);
    chk("b2b_stream", rx_bits(0, 32), 32'hFFFF_0000);
    chk("b2b_lasts", (rxl_q.size() == 32) && rxl_q[15] && rxl_q[31] && (last_count() == 2), 1);

    // Load presented while busy is ignored.
    rx_q.delete(); rxl_q.delete();
    load_word(16'hF00F);
    repeat (4) @(posedge clk);
    #1;
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_load_ready", bus.load_ready, 0);
    end
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
    drain(1'b0, n);
    chk("busy_word", rx_bits(0, 16), 32'h0000_F00F);
    chk("busy_bits", rx_q.size(), 16);

    // Asynchronous reset after five beats.
    load_word(16'hFFFF);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", bus.ser_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.ser_valid, 0);
    chk("async_rst_out", bus.ser_out, 0);
    chk("async_rst_ready", bus.load_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("after_rst_idle", bus.ser_valid, 0);
    rx_q.delete(); rxl_q.delete();
    load_word(16'h0001);
    drain(1'b0, n);
    chk("after_rst_word", rx_bits(0, 16), 32'h0000_0001);
    chk("after_rst_cycles", n, 16);

    // Random traffic; the per-cycle model does the checking.
    rx_q.delete(); rxl_q.delete();
    fired = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      fired = bus.load_valid && bus.load_ready;
      @(posedge clk);
      #1;
      if (fired || !bus.load_valid) begin
        bus.load_valid = ($urandom_range(0, 3) != 0);
        bus.load_data  = N'($urandom);
      end
      bus.ser_ready = ($urandom_range(0, 3) != 0);
    end
    bus.load_valid = 1'b0;
    drain(1'b0, n);
    chk("rand_bits_whole_words", rx_q.size() % N, 0);
    chk("rand_lasts", last_count(), rx_q.size() / N);
    chk("rand_model_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
